router_wr_framer: RTL and testbench

- Parametrised store-and-forward packet source for the write side of the 1xN router.
- Accepts a command (destination address, payload length) and the payload bytes from an upstream valid/ready source, and buffers the whole payload.
- Emits the router write protocol back-to-back: header, payload, parity. Stalls on router `busy`.
- Optionally monitors router `error` after each packet.

---
 rtl/router_wr_framer.sv | 210 +++++++++++++++++++++
 tb/tb_router_wr_framer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/router_wr_framer.sv
// Store-and-forward write-side packet framer for the 1xN router: buffers a payload, then emits header/payload/parity.
// Optional post-packet error monitoring is enabled by defining ROUTER_WR_FRAMER_ERR_CNT_EN.
module router_wr_framer #(
   parameter int ADDR_W   = 2,
   parameter int LEN_W    = 6,
   parameter int DATA_W   = 8,
   parameter int ERR_WAIT = 3
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              pl_valid,
   output logic              pl_ready,
   input  logic [DATA_W-1:0] pl_data,
   output logic              pkt_valid,
   output logic [DATA_W-1:0] data_in,
   input  logic              busy,
   input  logic              error,
   output logic              pkt_done,
   output logic [7:0]        err_cnt
);

   localparam int DEPTH = (2 ** LEN_W) - 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_HDR,
      S_BODY,
      S_PAR
`ifdef ROUTER_WR_FRAMER_ERR_CNT_EN
      , S_CHK
`endif
   } state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_wptr;
   logic [LEN_W-1:0]  r_rptr;
   logic [DATA_W-1:0] r_parity;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_cmd_ready;
   logic              r_pl_ready;
   logic              r_done;
   logic [DATA_W-1:0] r_buf [DEPTH];

   logic              w_cmd_fire;
   logic              w_pl_fire;
   logic              w_last_wr;
   logic [DATA_W-1:0] w_hdr_cmd;
   logic [DATA_W-1:0] w_hdr_reg;

   assign w_cmd_fire = cmd_valid & r_cmd_ready;
   assign w_pl_fire  = pl_valid & r_pl_ready;
   assign w_last_wr  = ((r_wptr + LEN_W'(1)) == r_len);
   assign w_hdr_cmd  = DATA_W'({cmd_len, cmd_addr});
   assign w_hdr_reg  = DATA_W'({r_len, r_addr});

`ifdef ROUTER_WR_FRAMER_ERR_CNT_EN
   localparam int CHK_W = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;
   logic [CHK_W-1:0] r_chk_cnt;
   logic             r_err_seen;
   logic [7:0]       r_err_cnt;
   assign err_cnt = r_err_cnt;
`else
   logic w_unused_err;
   assign w_unused_err = error & (ERR_WAIT != 0);
   assign err_cnt      = 8'd0;
`endif

   assign cmd_ready = r_cmd_ready;
   assign pl_ready  = r_pl_ready;
   assign pkt_valid = r_valid;
   assign data_in   = r_data;
   assign pkt_done  = r_done;

   // Payload storage carries no reset so it maps onto block RAM.
   always_ff @(posedge clock) begin
      if (w_pl_fire) begin
         r_buf[r_wptr] <= pl_data;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_len       <= '0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_parity    <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_cmd_ready <= 1'b0;
         r_pl_ready  <= 1'b0;
         r_done      <= 1'b0;
`ifdef ROUTER_WR_FRAMER_ERR_CNT_EN
         r_chk_cnt   <= '0;
         r_err_seen  <= 1'b0;
         r_err_cnt   <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_wptr <= '0;
               r_rptr <= '0;
               if (w_cmd_fire) begin
                  r_addr      <= cmd_addr;
                  r_len       <= cmd_len;
                  r_parity    <= w_hdr_cmd;
                  r_cmd_ready <= 1'b0;
                  if (cmd_len == '0) begin
                     r_state <= S_HDR;
                     r_data  <= w_hdr_cmd;
                     r_valid <= 1'b1;
                  end else begin
                     r_state    <= S_LOAD;
                     r_pl_ready <= 1'b1;
                  end
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end

            S_LOAD: begin
               if (w_pl_fire) begin
                  r_wptr   <= r_wptr + LEN_W'(1);
                  r_parity <= r_parity ^ pl_data;
                  if (w_last_wr) begin
                     r_pl_ready <= 1'b0;
                     r_state    <= S_HDR;
                     r_data     <= w_hdr_reg;
                     r_valid    <= 1'b1;
                  end
               end
            end

            S_HDR: begin
               if (!busy) begin
                  if (r_len != '0) begin
                     r_state <= S_BODY;
                     r_data  <= r_buf[r_rptr];
                     r_rptr  <= r_rptr + LEN_W'(1);
                  end else begin
                     r_state <= S_PAR;
                     r_data  <= r_parity;
                     r_valid <= 1'b0;
                  end
               end
            end

            // r_rptr is always one ahead of the byte currently on data_in.
            S_BODY: begin
               if (!busy) begin
                  if (r_rptr == r_len) begin
                     r_state <= S_PAR;
                     r_data  <= r_parity;
                     r_valid <= 1'b0;
                  end else begin
                     r_data <= r_buf[r_rptr];
                     r_rptr <= r_rptr + LEN_W'(1);
                  end
               end
            end

            S_PAR: begin
               if (!busy) begin
                  r_data <= '0;
`ifdef ROUTER_WR_FRAMER_ERR_CNT_EN
                  r_state    <= S_CHK;
                  r_chk_cnt  <= '0;
                  r_err_seen <= 1'b0;
`else
                  r_state     <= S_IDLE;
                  r_done      <= 1'b1;
                  r_cmd_ready <= 1'b1;
`endif
               end
            end

`ifdef ROUTER_WR_FRAMER_ERR_CNT_EN
            S_CHK: begin
               r_err_seen <= r_err_seen | error;
               if (r_chk_cnt == CHK_W'(ERR_WAIT - 1)) begin
                  r_state     <= S_IDLE;
                  r_done      <= 1'b1;
                  r_cmd_ready <= 1'b1;
                  if ((r_err_seen | error) && (r_err_cnt != 8'hFF)) begin
                     r_err_cnt <= r_err_cnt + 8'd1;
                  end
               end else begin
                  r_chk_cnt <= r_chk_cnt + CHK_W'(1);
               end
            end
`endif

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_router_wr_framer.sv
// Randomised self-checking bench for router_wr_framer against a packet-level reference model.
// Define ROUTER_WR_FRAMER_ERR_CNT_EN for both files to exercise the error counter.
module tb_router_wr_framer;

   localparam int ADDR_W   = 2;
   localparam int LEN_W    = 6;
   localparam int DATA_W   = 8;
   localparam int ERR_WAIT = 3;

   logic              clock = 1'b0;
   logic              resetn = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic [LEN_W-1:0]  cmd_len = '0;
   logic              pl_valid = 1'b0;
   logic              pl_ready;
   logic [DATA_W-1:0] pl_data = '0;
   logic              pkt_valid;
   logic [DATA_W-1:0] data_in;
   logic              busy = 1'b0;
   logic              error = 1'b0;
   logic              pkt_done;
   logic [7:0]        err_cnt;

   always #5 clock = ~clock;

   router_wr_framer #(
      .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W), .ERR_WAIT(ERR_WAIT)
   ) dut (
      .clock(clock), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
      .pkt_valid(pkt_valid), .data_in(data_in), .busy(busy), .error(error),
      .pkt_done(pkt_done), .err_cnt(err_cnt)
   );

   int         n_checks = 0;
   int         n_fail = 0;
   int         exp_err = 0;
   logic [1:0] cur_addr;
   logic [5:0] cur_len;
   logic [7:0] cur_pl[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_valid"}, pkt_valid, 1'b0);
      check({tag, "_data"}, data_in, 8'h00);
      check({tag, "_done"}, pkt_done, 1'b0);
      check({tag, "_cmd_ready"}, cmd_ready, 1'b0);
      check({tag, "_pl_ready"}, pl_ready, 1'b0);
      check({tag, "_err_cnt"}, err_cnt, 8'h00);
   endtask

   // vmode: 0 = pl_valid always high, 1 = random gaps, 2 = toggling every cycle
   task automatic load_pkt(input int vmode);
      int  budget;
      int  idx;
      bit  fire;
      budget = 0;
      while (!cmd_ready && budget < 20) begin
         @(negedge clock);
         budget++;
      end
      check("cmd_ready_wait", cmd_ready, 1'b1);
      cmd_valid = 1'b1;
      cmd_addr  = cur_addr;
      cmd_len   = cur_len;
      @(negedge clock);
      cmd_valid = 1'b0;
      cmd_addr  = 2'($urandom);
      cmd_len   = 6'($urandom);
      check("cmd_ready_after_accept", cmd_ready, 1'b0);
      check("pl_ready_start", pl_ready, cur_len != 0);
      idx    = 0;
      budget = 0;
      while (idx < int'(cur_len) && budget < 1000) begin
         case (vmode)
            0:       pl_valid = 1'b1;
            2:       pl_valid = (budget % 2) == 0;
            default: pl_valid = $urandom_range(0, 2) != 0;
         endcase
         pl_data   = pl_valid ? cur_pl[idx] : 8'($urandom);
         cmd_valid = 1'($urandom);
         fire      = pl_valid && pl_ready;
         @(negedge clock);
         if (fire) idx++;
         budget++;
      end
      pl_valid  = 1'b0;
      cmd_valid = 1'b0;
      check("load_beats", idx, cur_len);
      check("pl_ready_end", pl_ready, 1'b0);
   endtask

   // bmode: 0 = never busy, 1 = random busy, 2 = busy twice while payload byte 1 is on the bus
   task automatic observe_pkt(input int bmode, input int err_at);
      logic [7:0] exp_beats[$];
      logic [7:0] par;
      int         i, budget, stall, held2;
      bit         consumed, par_done;
      exp_beats.push_back({cur_len, cur_addr});
      for (int k = 0; k < int'(cur_len); k++) exp_beats.push_back(cur_pl[k]);
      par = 8'h00;
      foreach (exp_beats[k]) par ^= exp_beats[k];
      i = 0; budget = 0; stall = 0; held2 = 0;
      while (i < exp_beats.size() && budget < 2000) begin
         check($sformatf("beat%0d_valid", i), pkt_valid, 1'b1);
         check($sformatf("beat%0d_data", i), data_in, exp_beats[i]);
         check("done_early", pkt_done, 1'b0);
         if (i == 2) held2++;
         case (bmode)
            1: busy = $urandom_range(0, 3) == 0;
            2: begin
               busy = (i == 2) && (stall < 2);
               if (busy) stall++;
            end
            default: busy = 1'b0;
         endcase
         consumed = !busy;
         @(negedge clock);
         if (consumed) i++;
         budget++;
      end
      check("beats_sent", i, exp_beats.size());
      if (bmode == 2 && cur_len >= 2) check("held_cycles", held2, 3);
      par_done = 1'b0;
      budget   = 0;
      while (!par_done && budget < 100) begin
         check("par_valid", pkt_valid, 1'b0);
         check("par_data", data_in, par);
         busy = (bmode == 1) ? 1'($urandom) : 1'b0;
`ifndef ROUTER_WR_FRAMER_ERR_CNT_EN
         error = 1'($urandom);
`endif
         consumed = !busy;
         @(negedge clock);
         if (consumed) par_done = 1'b1;
         budget++;
      end
      busy  = 1'b0;
      error = 1'b0;
      check("par_consumed", par_done, 1'b1);
`ifdef ROUTER_WR_FRAMER_ERR_CNT_EN
      for (int c = 0; c < ERR_WAIT; c++) begin
         check("done_in_chk", pkt_done, 1'b0);
         check("data_in_chk", data_in, 8'h00);
         error = (c == err_at);
         @(negedge clock);
      end
      error = 1'b0;
      if (err_at >= 0 && exp_err < 255) exp_err++;
`endif
      check("pkt_done", pkt_done, 1'b1);
      check("data_after", data_in, 8'h00);
      check("valid_after", pkt_valid, 1'b0);
      check("err_cnt", err_cnt, exp_err);
      @(negedge clock);
      check("pkt_done_pulse", pkt_done, 1'b0);
      check("cmd_ready_idle", cmd_ready, 1'b1);
      $display("PKT addr=%0d len=%0d parity=%02h err_cnt=%0d", cur_addr, cur_len, par, err_cnt);
   endtask

   task automatic set_pkt(input logic [1:0] a, input logic [5:0] l, input int pattern);
      cur_addr = a;
      cur_len  = l;
      cur_pl.delete();
      for (int k = 0; k < int'(l); k++) begin
         if (pattern == 0) cur_pl.push_back(8'($urandom));
         else              cur_pl.push_back(8'(k));
      end
   endtask

   initial begin
      repeat (3) @(negedge clock);
      check_idle_outputs("reset");
      resetn = 1'b1;
      @(negedge clock);

      // Directed packet 0D,11,22,33 then parity 0D
      set_pkt(2'd1, 6'd3, 1);
      cur_pl[0] = 8'h11; cur_pl[1] = 8'h22; cur_pl[2] = 8'h33;
      load_pkt(0);
      observe_pkt(0, -1);

      // Same packet with a two-cycle stall on byte 22
      load_pkt(0);
      observe_pkt(2, -1);

      // Zero-length packet: header and parity both 02, no payload handshake
      set_pkt(2'd2, 6'd0, 0);
      load_pkt(0);
      observe_pkt(0, -1);

      // Maximum length with toggling pl_valid
      set_pkt(2'd3, 6'd63, 1);
      load_pkt(2);
      observe_pkt(0, -1);

      // Reset in the middle of the payload
      set_pkt(2'd1, 6'd5, 0);
      load_pkt(0);
      busy = 1'b0;
      @(negedge clock);
      @(negedge clock);
      #2 resetn = 1'b0;
      #1 check_idle_outputs("midreset");
      exp_err = 0;
      @(negedge clock);
      resetn = 1'b1;
      set_pkt(2'd0, 6'd1, 0);
      cur_pl[0] = 8'hAA;
      load_pkt(0);
      observe_pkt(0, -1);

      // Randomised packets
      for (int n = 0; n < 30; n++) begin
         int r;
         logic [5:0] l;
         r = $urandom_range(0, 9);
         if (r == 0)      l = 6'd0;
         else if (r == 1) l = 6'd63;
         else             l = 6'($urandom_range(1, 62));
         set_pkt(2'($urandom), l, 0);
         load_pkt(1);
         observe_pkt(1, -1);
      end

`ifdef ROUTER_WR_FRAMER_ERR_CNT_EN
      set_pkt(2'd1, 6'd2, 0);
      load_pkt(0);
      observe_pkt(0, 0);
      set_pkt(2'd2, 6'd0, 0);
      load_pkt(0);
      observe_pkt(0, -1);
      load_pkt(0);
      observe_pkt(0, ERR_WAIT - 1);
      for (int n = 0; n < 256; n++) begin
         set_pkt(2'($urandom), 6'd0, 0);
         load_pkt(0);
         observe_pkt(0, $urandom_range(0, ERR_WAIT - 1));
      end
      check("err_cnt_saturated", err_cnt, 8'hFF);
`else
      check("err_cnt_disabled", err_cnt, 8'h00);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
